alu_rf_sequencer: RTL
=====================

ALU_RF_SEQUENCER -- requirements
Module: alu_rf_sequencer

Interface
REQ-001 SHALL use parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL use parameter OPW, default 5, meaning ALU opcode width.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered; cmd_ready  out  1  sequencer can accept.
REQ-006 cmd_op  in  OPW  ALU opcode; cmd_rs1, cmd_rs2, cmd_rd  in  5 each  register addresses; cmd_wb  in  1  write result to rd.
REQ-007 rf_a1, rf_a2, rf_a3  out  5  RF addresses; rf_we3  out  1  RF write enable; rf_wd3  out  XLEN  RF write data.
REQ-008 rf_rd1, rf_rd2  in  XLEN  RF combinational read data.
REQ-009 alu_a, alu_b  out  XLEN  ALU operands; alu_op  out  OPW  ALU opcode.
REQ-010 alu_result  in  XLEN; alu_flag  in  1  ALU outputs, combinational.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  XLEN; rsp_flag  out  1; rsp_err  out  1  illegal opcode.

Function
REQ-012 SHALL implement FSM states IDLE, READ, EXEC, WB, RESP.
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready, latching op, rs1, rs2, rd, wb.
REQ-014 Legal opcodes 0..13 (ADD, SUB, XOR, OR, AND, SRA, SRL, SLL, LTS, LTU, GES, GEU, EQ, NE); accepted legal command: IDLE->READ.
REQ-015 Accepted opcode >13: IDLE->RESP directly, rsp_err=1, rsp_result=0, rsp_flag=0, no RF write.
REQ-016 READ: drive rf_a1=rs1, rf_a2=rs2; capture rf_rd1/rf_rd2 into operand registers; ->EXEC.
REQ-017 EXEC: alu_a/alu_b from operand registers, alu_op=latched op; capture alu_result, alu_flag; ->WB.
REQ-018 WB: rf_a3=rd, rf_wd3=captured result, rf_we3=1 for exactly this cycle iff wb=1 and rd!=0; ->RESP.
REQ-019 RESP: rsp_valid=1; rsp_result/rsp_flag/rsp_err held stable until rsp_valid && rsp_ready, then ->IDLE.
REQ-020 Latency: accept edge N -> rsp_valid high in cycle N+4 (legal) or N+1 (illegal); min issue interval 5 cycles (legal).
REQ-021 rf_we3 SHALL be 0 in every state except WB; alu_* and rf_a* SHALL be 0 outside their active states.
REQ-022 cmd_valid in non-IDLE states SHALL be ignored; no command queueing.

Reset
REQ-023 rst SHALL force IDLE and clear all latched fields, operand and result registers.
REQ-024 During and after rst: cmd_ready=0 while rst=1, then 1; rsp_valid=0, rf_we3=0, rsp_err=0, all data outputs 0.
REQ-025 rst asserted mid-operation (any state) SHALL abandon the command; no RF write and no response occur.

Configuration
REQ-026 Macro ALU_SEQ_PERF_CNT_EN defined: extra output perf_cnt (32 bits) counting completed legal responses (rsp handshake with rsp_err=0), wraps 0xFFFFFFFF->0, cleared by rst.
REQ-027 Macro undefined: no perf_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold ALU opcode constants (0..13), OPW, XLEN, the FSM state enum and the illegal-opcode threshold.
REQ-029 One sub-module alu_seq_fsm (state register and next-state logic) is natural; datapath registers stay in the top module.

Verification
REQ-030 RF x1=1, x2=2; cmd ADD rs1=1 rs2=2 rd=3 wb=1 -> rf_we3 once with a3=3 wd3=3; rsp_result=3, rsp_flag=0, rsp_valid 4 cycles after accept.
REQ-031 x1=5, x2=0x10; cmd LTS (8) rd=0 wb=1 -> rsp_result=1, rsp_flag=1, rf_we3 never asserted.
REQ-032 cmd_op=20 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0, no RF write.
REQ-033 Response with rsp_ready held low 3 cycles -> rsp_valid and payload stable, cmd_ready=0 throughout; IDLE the cycle after handshake.
REQ-034 rst asserted in EXEC -> next cycle IDLE, rf_we3=0, no rsp_valid; subsequent ADD completes normally.
REQ-035 With ALU_SEQ_PERF_CNT_EN: 3 legal + 1 illegal command -> perf_cnt=3.

Source files
------------

// File: rtl/alu_rf_sequencer_pkg.sv
// Shared constants and types for the ALU / register-file command sequencer.
package alu_rf_sequencer_pkg;

  localparam int unsigned SEQ_XLEN = 32;
  localparam int unsigned SEQ_OPW  = 5;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_XOR = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_AND = 4;
  localparam int unsigned OP_SRA = 5;
  localparam int unsigned OP_SRL = 6;
  localparam int unsigned OP_SLL = 7;
  localparam int unsigned OP_LTS = 8;
  localparam int unsigned OP_LTU = 9;
  localparam int unsigned OP_GES = 10;
  localparam int unsigned OP_GEU = 11;
  localparam int unsigned OP_EQ  = 12;
  localparam int unsigned OP_NE  = 13;

  // Opcodes at or above this value are rejected with rsp_err.
  localparam int unsigned OP_ILLEGAL_MIN = 14;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wb;
  } cmd_fields_t;

endpackage

// File: rtl/alu_seq_fsm.sv
// Sequencer control FSM: state register plus next-state decode (next state exported
// so the datapath can register its outputs to line up with the state).
module alu_seq_fsm
  import alu_rf_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   accept_i,
  input  logic   illegal_i,
  input  logic   rsp_done_i,
  output state_e state_o,
  output state_e next_o
);

  state_e state_q;
  state_e state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_i) state_d = illegal_i ? S_RESP : S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_RESP;
      S_RESP:  if (rsp_done_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign state_o = state_q;
  assign next_o  = state_d;

endmodule

// File: rtl/alu_rf_sequencer.sv
// Sequences one command at a time through RF read, ALU execute, RF writeback and response.
// Optional ALU_SEQ_PERF_CNT_EN adds perf_cnt, a count of completed legal responses.
module alu_rf_sequencer
  import alu_rf_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = SEQ_XLEN,
  parameter int unsigned OPW  = SEQ_OPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [4:0]      cmd_rs1,
  input  logic [4:0]      cmd_rs2,
  input  logic [4:0]      cmd_rd,
  input  logic            cmd_wb,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  output logic [4:0]      rf_a3,
  output logic            rf_we3,
  output logic [XLEN-1:0] rf_wd3,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_flag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_flag,
  output logic            rsp_err
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cnt
`endif
);

  state_e      state_q;
  state_e      state_d;
  logic        accept;
  logic        illegal;
  logic        rsp_done;

  cmd_fields_t cmd_q, cmd_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic            flag_q, flag_d, err_q, err_d;

  logic            cmd_ready_q, rf_we3_q, rsp_valid_q, rsp_flag_q, rsp_err_q;
  logic [4:0]      rf_a1_q, rf_a2_q, rf_a3_q;
  logic [XLEN-1:0] rf_wd3_q, alu_a_q, alu_b_q, rsp_result_q;
  logic [OPW-1:0]  alu_op_q;

  assign accept   = cmd_valid && cmd_ready_q;
  assign illegal  = 32'(cmd_op) >= OP_ILLEGAL_MIN;
  assign rsp_done = rsp_valid_q && rsp_ready;

  alu_seq_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .accept_i   (accept),
    .illegal_i  (illegal),
    .rsp_done_i (rsp_done),
    .state_o    (state_q),
    .next_o     (state_d)
  );

  // Datapath next values: command latch, operand capture, result capture.
  always_comb begin
    cmd_d  = cmd_q;
    op_d   = op_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    res_d  = res_q;
    flag_d = flag_q;
    err_d  = err_q;
    if (accept) begin
      cmd_d  = '{rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd, wb: cmd_wb};
      op_d   = cmd_op;
      res_d  = '0;
      flag_d = 1'b0;
      err_d  = illegal;
    end
    if (state_q == S_READ) begin
      opa_d = rf_rd1;
      opb_d = rf_rd2;
    end
    if (state_q == S_EXEC) begin
      res_d  = alu_result;
      flag_d = alu_flag;
    end
  end

  // Outputs are registered from the next state so each is valid exactly in its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q        <= '0;
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      res_q        <= '0;
      flag_q       <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rf_a1_q      <= '0;
      rf_a2_q      <= '0;
      rf_a3_q      <= '0;
      rf_we3_q     <= 1'b0;
      rf_wd3_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      res_q        <= res_d;
      flag_q       <= flag_d;
      err_q        <= err_d;
      cmd_ready_q  <= (state_d == S_IDLE);
      rf_a1_q      <= (state_d == S_READ) ? cmd_d.rs1 : 5'd0;
      rf_a2_q      <= (state_d == S_READ) ? cmd_d.rs2 : 5'd0;
      alu_a_q      <= (state_d == S_EXEC) ? opa_d : '0;
      alu_b_q      <= (state_d == S_EXEC) ? opb_d : '0;
      alu_op_q     <= (state_d == S_EXEC) ? op_d : '0;
      rf_a3_q      <= (state_d == S_WB) ? cmd_d.rd : 5'd0;
      rf_wd3_q     <= (state_d == S_WB) ? res_d : '0;
      rf_we3_q     <= (state_d == S_WB) && cmd_d.wb && (cmd_d.rd != 5'd0);
      rsp_valid_q  <= (state_d == S_RESP);
      rsp_result_q <= (state_d == S_RESP) ? res_d : '0;
      rsp_flag_q   <= (state_d == S_RESP) && flag_d;
      rsp_err_q    <= (state_d == S_RESP) && err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rf_a1      = rf_a1_q;
  assign rf_a2      = rf_a2_q;
  assign rf_a3      = rf_a3_q;
  assign rf_we3     = rf_we3_q;
  assign rf_wd3     = rf_wd3_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                       perf_cnt_q <= 32'd0;
    else if (rsp_done && !rsp_err_q) perf_cnt_q <= perf_cnt_q + 32'd1;
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule
